// File: rtl/game_move_scheduler.sv
// game_move_scheduler: merges key pulses and a level-scaled gravity tick
// into one serialized valid/ready motion command stream for the game core.
module game_move_scheduler #(
    parameter int TICK_DIV     = 50000,
    parameter int DROP_BASE_MS = 800,
    parameter int DROP_STEP_MS = 50,
    parameter int DROP_MIN_MS  = 100,
    parameter int LEVEL_STEP   = 10
) (
    input  logic        CLK_50M,
    input  logic        RST_N,
    input  logic [1:0]  game_state,
    input  logic        left_key_press,
    input  logic        right_key_press,
    input  logic        down_key_press,
    input  logic [11:0] score,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [1:0]  cmd_op,
    output logic [3:0]  level,
    output logic        overflow
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] OP_LEFT  = 2'b00;
    localparam logic [1:0] OP_RIGHT = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_GRAV  = 2'b11;

    localparam logic [1:0] GS_READY = 2'b00;
    localparam logic [1:0] GS_PLAY  = 2'b01;
    localparam logic [1:0] GS_PAUSE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic        cmd_valid_d;
    logic [1:0]  cmd_op_d;
    logic        load_left, load_right, load_down, load_grav;

    logic        pend_left, pend_right, pend_down, pend_grav;
    logic        pend_left_d, pend_right_d, pend_down_d, pend_grav_d;
    logic        overflow_d;

    logic [PW-1:0] pre;
    logic [11:0]   ms_cnt;
    logic [11:0]   period;
    logic [11:0]   period_m1;
    logic [11:0]   step_prod;
    logic [15:0]   level_thr;

    logic playing, paused, accept, accept_down, pre_wrap, grav_fire;

    assign playing     = (game_state == GS_PLAY);
    assign paused      = (game_state == GS_PAUSE);
    assign accept      = cmd_valid && cmd_ready;
    assign accept_down = playing && accept && (cmd_op == OP_DOWN);
    assign pre_wrap    = playing && (pre == PRE_LAST);
    assign grav_fire   = pre_wrap && !accept_down && (ms_cnt >= period_m1);
    assign level_thr   = (16'(level) + 16'd1) * 16'(LEVEL_STEP);

    // Gravity period from level, floored; a wrapped subtraction counts as floor.
    always_comb begin
        step_prod = 12'(level) * 12'(DROP_STEP_MS);
        period    = 12'(DROP_MIN_MS);
        if (step_prod < 12'(DROP_BASE_MS)) begin
            if ((12'(DROP_BASE_MS) - step_prod) >= 12'(DROP_MIN_MS)) begin
                period = 12'(DROP_BASE_MS) - step_prod;
            end
        end
        period_m1 = period - 12'd1;
    end

    // Command FSM state and registered handshake outputs.
    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= OP_LEFT;
        end else begin
            state_q   <= state_d;
            cmd_valid <= cmd_valid_d;
            cmd_op    <= cmd_op_d;
        end
    end

    // Arbitration (grav > down > left > right) and handshake sequencing.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid;
        cmd_op_d    = cmd_op;
        load_left   = 1'b0;
        load_right  = 1'b0;
        load_down   = 1'b0;
        load_grav   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_valid_d = 1'b0;
                if (playing) state_d = S_ARB;
            end
            S_ARB: begin
                cmd_valid_d = 1'b0;
                if (!playing) begin
                    state_d = S_IDLE;
                end else if (pend_grav) begin
                    load_grav   = 1'b1;
                    cmd_op_d    = OP_GRAV;
                    cmd_valid_d = 1'b1;
                    state_d     = S_WAIT;
                end else if (pend_down) begin
                    load_down   = 1'b1;
                    cmd_op_d    = OP_DOWN;
                    cmd_valid_d = 1'b1;
                    state_d     = S_WAIT;
                end else if (pend_left) begin
                    load_left   = 1'b1;
                    cmd_op_d    = OP_LEFT;
                    cmd_valid_d = 1'b1;
                    state_d     = S_WAIT;
                end else if (pend_right) begin
                    load_right  = 1'b1;
                    cmd_op_d    = OP_RIGHT;
                    cmd_valid_d = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!playing) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_ARB;
                end
            end
            default: begin
                cmd_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // Pending flags: a new event re-arms a flag even while it is being loaded.
    always_comb begin
        pend_left_d  = pend_left;
        pend_right_d = pend_right;
        pend_down_d  = pend_down;
        pend_grav_d  = pend_grav;
        overflow_d   = 1'b0;
        if (playing) begin
            pend_left_d  = (pend_left  & ~load_left)  | left_key_press;
            pend_right_d = (pend_right & ~load_right) | right_key_press;
            pend_down_d  = (pend_down  & ~load_down)  | down_key_press;
            pend_grav_d  = (pend_grav  & ~load_grav)  | grav_fire;
            overflow_d   = (left_key_press  & pend_left  & ~load_left)
                         | (right_key_press & pend_right & ~load_right)
                         | (down_key_press  & pend_down  & ~load_down)
                         | (grav_fire       & pend_grav  & ~load_grav);
        end else if (!paused) begin
            pend_left_d  = 1'b0;
            pend_right_d = 1'b0;
            pend_down_d  = 1'b0;
            pend_grav_d  = 1'b0;
        end
    end

    // Flag and overflow registers.
    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            pend_left  <= 1'b0;
            pend_right <= 1'b0;
            pend_down  <= 1'b0;
            pend_grav  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pend_left  <= pend_left_d;
            pend_right <= pend_right_d;
            pend_down  <= pend_down_d;
            pend_grav  <= pend_grav_d;
            overflow   <= overflow_d;
        end
    end

    // Gravity prescaler and millisecond counter; a soft drop restarts the interval.
    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            pre    <= '0;
            ms_cnt <= '0;
        end else if (playing) begin
            if (accept_down) begin
                pre    <= '0;
                ms_cnt <= '0;
            end else if (pre_wrap) begin
                pre    <= '0;
                ms_cnt <= (ms_cnt >= period_m1) ? 12'd0 : ms_cnt + 12'd1;
            end else begin
                pre <= pre + PW'(1);
            end
        end else if (!paused) begin
            pre    <= '0;
            ms_cnt <= '0;
        end
    end

    // Level climbs one step per cycle toward the score; cleared only when ready.
    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            level <= 4'd0;
        end else if (game_state == GS_READY) begin
            level <= 4'd0;
        end else if (playing && level != 4'hF && {4'd0, score} >= level_thr) begin
            level <= level + 4'd1;
        end
    end

endmodule

// File: doc/game_move_scheduler.md
# game_move_scheduler

Sequences all piece-motion commands into the block-killer game core. It merges the single-cycle left/right/down key pulses from the keyboard controller with an internally generated gravity tick into one serialized valid/ready command stream. The gravity period is derived from a level computed from the running score. It sits between the keyboard controller/state controller and the game core, replacing direct key wiring into the core.

## Interface
- TICK_DIV, 50000, clock cycles per 1 ms base tick
- DROP_BASE_MS, 800, gravity period at level 0 (ms)
- DROP_STEP_MS, 50, period reduction per level (ms)
- DROP_MIN_MS, 100, period floor (ms)
- LEVEL_STEP, 10, score points per level

Ports:
- CLK_50M  in  1  system clock
- RST_N  in  1  reset; **one clock; reset is synchronous and active-low**
- game_state  in  2  00 ready, 01 playing, 10 paused, 11 over
- left_key_press  in  1  single-cycle pulse
- right_key_press  in  1  single-cycle pulse
- down_key_press  in  1  single-cycle pulse (soft drop)
- score  in  12  current score, unsigned
- cmd_ready  in  1  game core accepts command
- cmd_valid  out  1  command available
- cmd_op  out  2  00 left, 01 right, 10 soft down, 11 gravity drop
- level  out  4  current level, 0..15
- overflow  out  1  one-cycle pulse when an event is lost

## Operation
- One pending flag per source: pend_left, pend_right, pend_down, pend_grav.
- A key pulse while playing sets its flag at the next edge.
  - If the flag is already set and is not being loaded that cycle, the event is dropped and overflow pulses for 1 cycle.
  - Key pulses are ignored in all states other than 01.
- FSM states: IDLE, ARB, WAIT.
  - IDLE (game_state != 01): cmd_valid=0. Goes to ARB when game_state=01.
  - ARB: if any flag is set, pick the highest-priority flag (grav > down > left > right), load cmd_op, clear that flag, set cmd_valid, go to WAIT. Otherwise stay in ARB.
  - WAIT: hold cmd_valid and cmd_op stable until cmd_valid&&cmd_ready, then cmd_valid=0 and go to ARB.
- Capacity per source is one in flight plus one pending. A flag cleared on load may be set again by a new pulse while that command is in WAIT.
- Gravity timing:
  - Prescaler pre counts 0..TICK_DIV-1 while in state 01.
  - ms_cnt increments on each pre wrap.
  - On a pre wrap with ms_cnt >= period-1: ms_cnt=0 and pend_grav is set. If pend_grav is already set, overflow pulses.
  - The >= compare covers the period shrinking below the current count.
- Acceptance of op 10 resets pre and ms_cnt to 0.
- period = max(DROP_BASE_MS - level*DROP_STEP_MS, DROP_MIN_MS), evaluated in 12-bit unsigned arithmetic. Subtraction underflow is treated as floor.
- Level, in state 01 only:
  - Increments by 1 per cycle while score >= (level+1)*LEVEL_STEP and level < 15.
  - Never decrements in state 01.
  - Cleared to 0 in state 00; held in 10 and 11.
- Leaving state 01 in WAIT (to 10/11/00): the in-flight command is withdrawn and discarded, with cmd_valid=0 at the next edge. This is the only permitted valid drop without ready.
- State 10 (paused): pre, ms_cnt and flags are frozen and retained.
- States 00 and 11: all flags, pre and ms_cnt are cleared.

## Timing
- Reset values: cmd_valid=0, cmd_op=00, level=0, overflow=0, all flags/counters 0, FSM=IDLE.
- Latency from key pulse in cycle N (FSM in ARB, no higher-priority flag pending): flag set at N+1, cmd_valid=1 at N+2.
- After accept in cycle M: cmd_valid=0 at M+1; the next command is valid no earlier than M+2.
- Gravity interval is period*TICK_DIV cycles from entering 01, or from the last op-10 accept or gravity wrap.
- A level change takes effect on the ms_cnt compare the cycle after level updates.
- A pulse coinciding with its own flag being loaded is captured, not dropped.

## Test plan
- Setup: TICK_DIV=4, DROP_BASE_MS=8, DROP_STEP_MS=2, DROP_MIN_MS=2, LEVEL_STEP=10; reset, then game_state=01, cmd_ready=1.
- Single key: left pulse at cycle 10 -> cmd_valid=1, cmd_op=00 at cycle 12 for exactly 1 cycle; no other command before gravity.
- Gravity: no keys, score=0 -> op 11 commands spaced exactly 32 cycles. Accept op 10 mid-interval -> next op 11 arrives 32 cycles after that accept.
- Priority and stability: cmd_ready=0, then left, right and down pulses in the same cycle -> op 10 held stable while ready=0. Release ready -> ops 10, 00, 01 in order, each separated by a 1-cycle valid gap.
- Overflow: cmd_ready=0, three left pulses -> overflow pulse on the third. Release ready -> exactly two op 00 commands.
- Level:
  - score=25 -> level=2 within 3 cycles and gravity spacing becomes 16 cycles.
  - score=1000 -> level=15 and spacing 8 cycles (floor).
- State changes:
  - cmd_valid=1, then game_state=10 -> cmd_valid=0 next cycle and counters frozen for 100 cycles. Back to 01 -> gravity resumes from the frozen count.
  - game_state=00 -> level=0 and flags cleared.
